// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC interpolation and decimation chains.
package cic_pkg;

  localparam int N     = 6;
  localparam int LOG2R = 7;

  function automatic int clog2(input int value);
    int r;
    int v;
    v = value - 1;
    for (r = 0; v > 0; r++) begin
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision width for an N-stage, M=1 CIC whose rate change is 2^log2r.
  function automatic int cic_out_w(input int in_w, input int n, input int log2r);
    return in_w + (n - 1) * log2r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One low-rate comb stage: registered c = in - d, with d <= in on every valid sample.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = cic_out_w(2, cic_pkg::N, cic_pkg::LOG2R)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         vld_in,
  output logic [W-1:0] dout,
  output logic         vld_out
);

  logic [W-1:0] c_q, c_d;
  logic [W-1:0] dly_q, dly_d;
  logic         vld_q, vld_d;

  // Difference and delay only advance when a sample is present.
  always_comb begin
    c_d   = c_q;
    dly_d = dly_q;
    vld_d = vld_in;
    if (vld_in) begin
      c_d   = din - dly_q;
      dly_d = din;
    end else begin
      c_d   = c_q;
      dly_d = dly_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= {W{1'b0}};
      dly_q <= {W{1'b0}};
      vld_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      dly_q <= dly_d;
      vld_q <= vld_d;
    end
  end

  assign dout    = c_q;
  assign vld_out = vld_q;

endmodule

// File: rtl/cic_interp.sv
// N-stage CIC interpolator (M=1, R=2^LOG2R): low-rate combs, zero-stuffing, high-rate integrators.
module cic_interp
  import cic_pkg::*;
#(
  parameter int  IN_W  = 2,
  parameter int  N     = cic_pkg::N,
  parameter int  LOG2R = cic_pkg::LOG2R,
  localparam int OUT_W = cic_out_w(IN_W, N, LOG2R)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  Xin,
  input  logic                    din_vld,
  output logic                    din_rdy,
  output logic signed [OUT_W-1:0] Yout,
  output logic                    dout_vld,
  output logic                    underrun
);

  logic [LOG2R-1:0]        phase_q, phase_d;
  logic                    slot_s;
  logic [OUT_W-1:0]        comb_in_s;
  logic [N:0][OUT_W-1:0]   comb_dat_s;
  logic [N:0]              comb_vld_s;
  logic [OUT_W-1:0]        up_s;
  logic [N-1:0][OUT_W-1:0] integ_q, integ_d;
  logic [OUT_W-1:0]        yout_q, yout_d;
  logic [N:0]              vld_sr_q, vld_sr_d;
  logic                    underrun_q, underrun_d;

  // Slot detection; a missed slot still pushes a zero through the combs.
  always_comb begin
    phase_d    = phase_q + {{(LOG2R-1){1'b0}}, 1'b1};
    slot_s     = (phase_q == {LOG2R{1'b0}}) && !rst;
    underrun_d = slot_s && !din_vld;
    if (din_vld) begin
      comb_in_s = {{(OUT_W-IN_W){Xin[IN_W-1]}}, Xin};
    end else begin
      comb_in_s = {OUT_W{1'b0}};
    end
  end

  assign comb_dat_s[0] = comb_in_s;
  assign comb_vld_s[0] = slot_s;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.W(OUT_W)) u_comb (
      .clk     (clk),
      .rst     (rst),
      .din     (comb_dat_s[k]),
      .vld_in  (comb_vld_s[k]),
      .dout    (comb_dat_s[k+1]),
      .vld_out (comb_vld_s[k+1])
    );
  end

  // Upsample by zero-stuffing, then integrate at the full rate (wrap-around is intended).
  always_comb begin
    if (comb_vld_s[N]) begin
      up_s = comb_dat_s[N];
    end else begin
      up_s = {OUT_W{1'b0}};
    end
    integ_d[0] = integ_q[0] + up_s;
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    yout_d = integ_q[N-1];
    // Sticky flag delayed N+1 cycles past the first comb output.
    vld_sr_d = {vld_sr_q[N-1:0], vld_sr_q[0] | comb_vld_s[N]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= {LOG2R{1'b0}};
      integ_q    <= {(N*OUT_W){1'b0}};
      yout_q     <= {OUT_W{1'b0}};
      vld_sr_q   <= {(N+1){1'b0}};
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      integ_q    <= integ_d;
      yout_q     <= yout_d;
      vld_sr_q   <= vld_sr_d;
      underrun_q <= underrun_d;
    end
  end

  assign din_rdy  = slot_s;
  assign Yout     = $signed(yout_q);
  assign dout_vld = vld_sr_q[N];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: convolution-kernel model checked every cycle plus directed literal checks.
module tb_cic_interp;

  localparam int N     = 6;
  localparam int R     = 128;
  localparam int OUT_W = 37;
  localparam int LAT   = 2*N + 1;
  localparam int HL    = N*(R-1) + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    din_vld = 1'b1;
  logic signed [1:0]       xin = 2'sd1;
  logic                    din_rdy;
  logic signed [OUT_W-1:0] yout;
  logic                    dout_vld;
  logic                    underrun;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  int     under_seen = 0;
  longint h[HL];

  cic_interp dut (
    .clk      (clk),
    .rst      (rst),
    .Xin      (xin),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .Yout     (yout),
    .dout_vld (dout_vld),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Overall impulse response: N-fold convolution of a length-R boxcar.
  initial begin
    longint tmp[HL];
    longint acc;
    int len;
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < len + R - 1; i++) begin
        acc = 0;
        for (int k = 0; k < R; k++) begin
          if (i - k >= 0 && i - k < len) acc += h[i-k];
        end
        tmp[i] = acc;
      end
      len = len + R - 1;
      for (int i = 0; i < len; i++) h[i] = tmp[i];
    end
  end

  // Model: Yout(t0+LAT+n) = sum_j x[j] * h[n - j*R], slots every R cycles from t0.
  initial begin
    longint xs[$];
    bit     miss[$];
    int     t0;
    bit     rst_prev;
    int     p;
    int     n;
    longint y;
    logic signed [OUT_W-1:0] e;
    bit     er;
    t0 = 0;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("din_rdy_in_reset", din_rdy, 0);
        if (rst_prev) begin
          chk("yout_in_reset", yout, 0);
          chk("dout_vld_in_reset", dout_vld, 0);
          chk("underrun_in_reset", underrun, 0);
        end
        rst_prev = 1'b1;
        xs.delete();
        miss.delete();
      end else begin
        if (rst_prev) t0 = cyc;
        rst_prev = 1'b0;
        p = cyc - t0;
        n = p - LAT;
        y = 0;
        if (n >= 0) begin
          for (int j = n / R; j >= 0 && n - j*R < HL; j--) begin
            if (j < xs.size()) y += xs[j] * h[n - j*R];
          end
        end
        e = y[OUT_W-1:0];
        if (p >= 1 && (p - 1) % R == 0 && (p - 1) / R < miss.size()) er = miss[(p-1)/R];
        else er = 1'b0;
        chk("din_rdy", din_rdy, (p % R == 0));
        chk("yout", yout, e);
        chk("dout_vld", dout_vld, (p >= LAT));
        chk("underrun", underrun, er);
        if (underrun === 1'b1) under_seen++;
        if (p % R == 0) begin
          xs.push_back(din_vld ? longint'(xin) : 64'sd0);
          miss.push_back(!din_vld);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  int t0s;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit v, input logic signed [1:0] x);
    din_vld = v;
    xin     = x;
    while ((cyc - t0s) % R != 0) tick();
    tick();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    longint imp[5];
    int     s;
    int     misses;
    int     u0;
    bit     v;
    logic signed [1:0] xr;
    imp = '{64'sd1, 64'sd6, 64'sd21, 64'sd56, 64'sd126};

    rst = 1'b1; din_vld = 1'b1; xin = 2'sd1;
    repeat (5) tick();
    rst = 1'b0;
    t0s = cyc;

    // Impulse in the first slot, zeros afterwards.
    send(1'b1, 2'sd1);
    xin = 2'sd0;
    wait_to(t0s + LAT - 1);
    @(negedge clk);
    chk("impulse_vld_before", dout_vld, 0);
    for (int i = 0; i < 5; i++) begin
      wait_to(t0s + LAT + i);
      @(negedge clk);
      chk("impulse_yout", yout, imp[i]);
      chk("impulse_vld", dout_vld, 1);
    end
    repeat (7) send(1'b1, 2'sd0);

    // DC = 1 settles at 2^35.
    repeat (8) send(1'b1, 2'sd1);
    repeat (20) tick();
    @(negedge clk);
    chk("dc_plus_one", yout, 64'sd34359738368);

    // One missed slot inside the DC stream.
    repeat (2) send(1'b1, 2'sd1);
    send(1'b0, 2'sd1);
    s = cyc - 1;
    din_vld = 1'b1;
    @(negedge clk);
    chk("underrun_pulse", underrun, 1);
    tick();
    @(negedge clk);
    chk("underrun_single", underrun, 0);
    wait_to(s + LAT);
    @(negedge clk);
    chk("underrun_dip", yout, 64'sd34359738367);
    repeat (7) send(1'b1, 2'sd1);

    // DC = -2 reaches -2^36 with no wrap.
    repeat (8) send(1'b1, -2'sd2);
    repeat (20) tick();
    @(negedge clk);
    chk("dc_minus_two", yout, -64'sd68719476736);

    // Single-cycle reset at phase 64 of a DC stream.
    repeat (3) send(1'b1, 2'sd1);
    s = cyc - 1;
    wait_to(s + 64);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t0s = cyc;
    @(negedge clk);
    chk("post_reset_yout", yout, 0);
    chk("post_reset_vld", dout_vld, 0);
    chk("post_reset_underrun", underrun, 0);
    chk("post_reset_rdy", din_rdy, 1);
    repeat (8) send(1'b1, 2'sd1);
    repeat (20) tick();
    @(negedge clk);
    chk("dc_after_reset", yout, 64'sd34359738368);

    // Random samples with random gaps.
    u0 = under_seen;
    misses = 0;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(6, 0) != 0);
      xr = 2'($urandom_range(3, 0));
      if (!v) misses++;
      send(v, xr);
    end
    din_vld = 1'b1;
    xin = 2'sd0;
    repeat (1000) tick();
    chk("underrun_count", under_seen - u0, misses);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
